rf_multiport_sb: RTL and testbench

- Parametrised successor to the ID-stage register file.
- Supports N read ports and M write ports, with configurable data width and depth.
- Optional write-to-read bypass; optional hardwired zero register.
- Integrated per-register pending scoreboard, so the dual-issue ID stage can detect RAW hazards without a separate hazard table.
- Sits in ID: reads feed BusA/BusB of each issue slot; writes come from WB slots; issue marks come from ID dispatch.

---
 rtl/rf_multiport_sb.sv | 133 +++++++++++++
 tb/tb_rf_multiport_sb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_multiport_sb.sv
// rf_multiport_sb: multi-ported register file with an integrated per-register
// pending scoreboard for RAW hazard detection in a dual-issue ID stage.
//
// Ports:
//   clk_i       clock; all state updates on the rising edge
//   rst_ni      asynchronous active-low reset
//   wr_en_i     per-port write enable (NUM_WR)
//   wr_addr_i   write indices, port i at [i*ADDR_W +: ADDR_W]
//   wr_data_i   write data, port i at [i*DATA_W +: DATA_W]
//   iss_en_i    per-slot issue mark; the destination becomes pending
//   iss_dst_i   issued destination indices, packed like wr_addr_i
//   flush_i     clears every pending bit; same-cycle issue marks are dropped
//   rd_addr_i   read indices (NUM_RD ports)
//   rd_data_o   combinational read data
//   rd_ready_o  1 = read value is valid (not pending, or forwarded this cycle)
//   pend_cnt_o  registered number of pending registers
module rf_multiport_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 4,
    parameter int unsigned NUM_WR   = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic [NUM_WR-1:0]        iss_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] iss_dst_i,
    input  logic                     flush_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_ready_o,
    output logic [ADDR_W:0]          pend_cnt_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [Depth];
    logic [DATA_W-1:0] regs_d [Depth];
    logic [Depth-1:0]  pend_q, pend_d;
    logic [Depth-1:0]  set_mask, clr_mask;
    logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;

    logic [DATA_W-1:0] rd_val [NUM_RD];
    logic [NUM_RD-1:0] rd_hit;

    // Write path: ascending port order so the highest-numbered port wins.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en_i[i]) begin
                regs_d[wr_addr_i[i*ADDR_W +: ADDR_W]] = wr_data_i[i*DATA_W +: DATA_W];
            end
        end
        if (ZERO_REG) begin
            regs_d[0] = '0;
        end
    end

    // Scoreboard: a new issue mark beats a completing write to the same index.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (iss_en_i[i]) begin
                set_mask[iss_dst_i[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
            if (wr_en_i[i]) begin
                clr_mask[wr_addr_i[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            set_mask[0] = 1'b0;
        end
        if (flush_i) begin
            pend_d = '0;
        end else begin
            pend_d = (pend_q & ~clr_mask) | set_mask;
        end
    end

    always_comb begin
        pend_cnt_d = '0;
        for (int r = 0; r < Depth; r++) begin
            pend_cnt_d = pend_cnt_d + (ADDR_W + 1)'(pend_d[r]);
        end
    end

    // Read path with optional same-cycle forwarding from the write ports.
    always_comb begin
        rd_data_o  = '0;
        rd_ready_o = '1;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_hit[k] = 1'b0;
            rd_val[k] = regs_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
            if (BYPASS) begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wr_en_i[i] &&
                        wr_addr_i[i*ADDR_W +: ADDR_W] == rd_addr_i[k*ADDR_W +: ADDR_W]) begin
                        rd_hit[k] = 1'b1;
                        rd_val[k] = wr_data_i[i*DATA_W +: DATA_W];
                    end
                end
            end
            if (ZERO_REG && rd_addr_i[k*ADDR_W +: ADDR_W] == '0) begin
                rd_val[k] = '0;
            end
            // Reset forces a quiet, all-ready view regardless of inputs.
            if (rst_ni) begin
                rd_data_o[k*DATA_W +: DATA_W] = rd_val[k];
                rd_ready_o[k] = ~pend_q[rd_addr_i[k*ADDR_W +: ADDR_W]] | rd_hit[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q     <= '{default: '0};
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt_o = pend_cnt_q;

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Bench for rf_multiport_sb: two instances (forwarding on / off) share stimulus;
// a high-level model is compared on every negative edge, plus literal checks.
module tb_rf_multiport_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NW-1:0] wr_en, iss_en;
    logic [NW*AW-1:0] wr_addr, iss_dst;
    logic [NW*DW-1:0] wr_data;
    logic          flush;
    logic [NR*AW-1:0] rd_addr;

    logic [NR*DW-1:0] rdb, rdn;
    logic [NR-1:0]    rrb, rrn;
    logic [AW:0]      pcb, pcn;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_regs [32];
    logic [31:0]   m_pend;

    always #5 clk = ~clk;

    rf_multiport_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                      .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_dst_i(iss_dst), .flush_i(flush),
        .rd_addr_i(rd_addr), .rd_data_o(rdb), .rd_ready_o(rrb), .pend_cnt_o(pcb)
    );

    rf_multiport_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                      .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_n (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_dst_i(iss_dst), .flush_i(flush),
        .rd_addr_i(rd_addr), .rd_data_o(rdn), .rd_ready_o(rrn), .pend_cnt_o(pcn)
    );

    function automatic logic [31:0] mask(input logic [NW-1:0] en,
                                         input logic [NW*AW-1:0] ad);
        logic [31:0] m = '0;
        for (int i = 0; i < NW; i++) if (en[i]) m[ad[i*AW +: AW]] = 1'b1;
        return m;
    endfunction

    // Model state: writes in port order (later NBA wins), pending as bit masks.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) m_regs[r] <= '0;
            m_pend <= '0;
        end else begin
            for (int i = 0; i < NW; i++)
                if (wr_en[i] && wr_addr[i*AW +: AW] != 0)
                    m_regs[wr_addr[i*AW +: AW]] <= wr_data[i*DW +: DW];
            m_pend <= flush ? 32'h0 :
                      ((m_pend & ~mask(wr_en, wr_addr)) | mask(iss_en, iss_dst)) & ~32'h1;
        end
    end

    function automatic logic fwd_hit(input int k);
        logic h = 1'b0;
        for (int i = 0; i < NW; i++)
            if (wr_en[i] && wr_addr[i*AW +: AW] == rd_addr[k*AW +: AW]) h = 1'b1;
        return h;
    endfunction

    function automatic logic [DW-1:0] exp_data(input int k, input logic byp);
        logic [AW-1:0] a = rd_addr[k*AW +: AW];
        logic [DW-1:0] d;
        if (!rst_n || a == 0) return '0;
        d = m_regs[a];
        if (byp)
            for (int i = 0; i < NW; i++)
                if (wr_en[i] && wr_addr[i*AW +: AW] == a) d = wr_data[i*DW +: DW];
        return d;
    endfunction

    function automatic logic exp_ready(input int k, input logic byp);
        if (!rst_n) return 1'b1;
        if (!m_pend[rd_addr[k*AW +: AW]]) return 1'b1;
        return byp && fwd_hit(k);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NR; k++) begin
            chk("model rd_data byp", rdb[k*DW +: DW], exp_data(k, 1'b1));
            chk("model rd_data nobyp", rdn[k*DW +: DW], exp_data(k, 1'b0));
            chk("model rd_ready byp", rrb[k], exp_ready(k, 1'b1));
            chk("model rd_ready nobyp", rrn[k], exp_ready(k, 1'b0));
        end
        chk("model pend_cnt byp", pcb, rst_n ? $countones(m_pend) : 0);
        chk("model pend_cnt nobyp", pcn, rst_n ? $countones(m_pend) : 0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; iss_en = '0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = '0; iss_dst = '0; flush = 1'b0; rd_addr = '0;
        #1;
        chk("reset pend_cnt", pcb, 0);
        chk("reset rd_ready", rrb, 4'hF);
        cyc();
        rst_n = 1'b1;

        // Every index reads zero and ready after reset.
        for (int c = 0; c < 8; c++) begin
            rd_addr = {5'(4*c+3), 5'(4*c+2), 5'(4*c+1), 5'(4*c)};
            #1;
            chk("post-reset rd_data", rdb, 128'h0);
            chk("post-reset rd_ready", rrb, 4'hF);
            cyc();
        end

        // r5 write forwarded only by the bypass instance.
        rd_addr = {5'd0, 5'd5, 5'd0, 5'd0};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        #1;
        chk("r5 bypass same cycle", rdb[2*DW +: DW], 32'hDEADBEEF);
        chk("r5 nobypass same cycle", rdn[2*DW +: DW], 32'h0);
        cyc(); idle();
        #1;
        chk("r5 nobypass next cycle", rdn[2*DW +: DW], 32'hDEADBEEF);

        // Both ports on r7: port1 wins. r0 ignores writes.
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2222, 32'h1111};
        cyc(); idle();
        rd_addr = {5'd0, 5'd0, 5'd0, 5'd7};
        #1;
        chk("r7 port1 wins", rdb[0 +: DW], 32'h2222);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h55};
        cyc(); idle();
        rd_addr = '0;
        #1;
        chk("r0 reads zero", rdn[0 +: DW], 32'h0);

        // Issue r3, r9; then complete r3.
        iss_en = 2'b11; iss_dst = {5'd9, 5'd3};
        cyc(); idle();
        rd_addr = {5'd0, 5'd0, 5'd9, 5'd3};
        #1;
        chk("r3 pending", rrb[0], 1'b0);
        chk("r9 pending", rrb[1], 1'b0);
        chk("pend_cnt two", pcb, 2);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hABC};
        #1;
        chk("r3 ready via bypass", rrb[0], 1'b1);
        chk("r3 not ready nobypass", rrn[0], 1'b0);
        cyc(); idle();
        #1;
        chk("pend_cnt after r3 write", pcb, 1);

        // Issue beats write on r4.
        iss_en = 2'b01; iss_dst = {5'd0, 5'd4};
        cyc(); idle();
        #1;
        chk("pend_cnt r4 issued", pcb, 2);
        iss_en = 2'b10; iss_dst = {5'd4, 5'd0};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h44};
        cyc(); idle();
        rd_addr = {5'd0, 5'd0, 5'd0, 5'd4};
        #1;
        chk("r4 stays pending", rrb[0], 1'b0);
        chk("pend_cnt unchanged", pcb, 2);

        // Flush wins over a same-cycle issue.
        iss_en = 2'b11; iss_dst = {5'd2, 5'd1};
        cyc();
        iss_en = 2'b01; iss_dst = {5'd0, 5'd3};
        cyc(); idle();
        #1;
        chk("pend_cnt five", pcb, 5);
        flush = 1'b1; iss_en = 2'b01; iss_dst = {5'd0, 5'd6};
        cyc(); idle();
        rd_addr = {5'd3, 5'd2, 5'd1, 5'd6};
        #1;
        chk("flush pend_cnt", pcb, 0);
        chk("flush all ready", rrb, 4'hF);

        // Asynchronous reset mid-run, with a forwarding write in flight.
        rd_addr = {5'd0, 5'd0, 5'd0, 5'd7};
        #1;
        chk("r7 before reset", rdb[0 +: DW], 32'h2222);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h99};
        #1;
        rst_n = 1'b0;
        #1;
        chk("in-reset rd_data byp", rdb, 128'h0);
        chk("in-reset rd_data nobyp", rdn, 128'h0);
        chk("in-reset rd_ready", rrb, 4'hF);
        cyc(); idle();
        rst_n = 1'b1;
        #1;
        chk("r7 cleared by reset", rdb[0 +: DW], 32'h0);

        // Random traffic on a narrow index range to force collisions.
        for (int n = 0; n < 300; n++) begin
            wr_en   = 2'($urandom);
            wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_data = {$urandom, $urandom};
            iss_en  = 2'($urandom);
            iss_dst = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            flush   = ($urandom_range(0, 15) == 0);
            rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            cyc();
        end
        idle();
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
